fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory read address, selects the next PC (sequential, branch, jump, jump-register) with one architectural delay slot, and registers the fetched word and its PC into the IF/ID pipeline register. The registered instruction word is the input to the D-stage field splitter and decoder.

---
 rtl/fetch_stage.sv | 96 +++++++++
 tb/tb_fetch_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the five-stage MIPS pipeline. Holds the PC,
//   addresses instruction memory, picks the next PC (sequential, branch,
//   jump, jump-register) with one architectural delay slot, and registers
//   the fetched word and its PC into the IF/ID pipeline register.
//
// Ports
//   clk          pipeline clock, rising edge
//   reset        asynchronous, active-high reset
//   stall        hold PC and IF/ID (from hazard unit)
//   flush        load a bubble (nop, pc 0) into IF/ID
//   npc_sel      00 PC+4, 01 taken branch, 10 j/jal, 11 jr/jalr
//   imm16_d      branch offset field of the D-stage instruction
//   index26_d    jump index field of the D-stage instruction
//   jr_target_d  forwarded rs value for jr/jalr
//   imem_addr    word address to instruction memory
//   imem_rdata   instruction word (combinational read of imem_addr)
//   pc_f         current PC
//   instr_d      IF/ID instruction word
//   pc_d         IF/ID PC
//   pc8_d        pc_d + 8, link value for jal/jalr
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter int          IM_ADDR_W = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic                 flush,
   input  logic [1:0]           npc_sel,
   input  logic [15:0]          imm16_d,
   input  logic [25:0]          index26_d,
   input  logic [31:0]          jr_target_d,
   output logic [IM_ADDR_W-1:0] imem_addr,
   input  logic [31:0]          imem_rdata,
   output logic [31:0]          pc_f,
   output logic [31:0]          instr_d,
   output logic [31:0]          pc_d,
   output logic [31:0]          pc8_d
);

   logic        [31:0] pc_q, pc_n_d;
   logic        [31:0] ifid_instr_q, ifid_instr_d;
   logic        [31:0] ifid_pc_q, ifid_pc_d;
   logic        [31:0] pc_off;
   logic signed [31:0] br_off;

   // Memory is based at RESET_PC; anything outside wraps modulo its size.
   assign pc_off    = pc_q - RESET_PC;
   assign imem_addr = IM_ADDR_W'(pc_off >> 2);

   assign br_off = {{14{imm16_d[15]}}, imm16_d, 2'b00};

   // Redirects use pc_d: the branch/jump is in D, the word now in F is its
   // delay slot and proceeds normally.
   always_comb begin
      pc_n_d = pc_q + 32'd4;
      unique case (npc_sel)
         2'b00: pc_n_d = pc_q + 32'd4;
         2'b01: pc_n_d = ifid_pc_q + 32'd4 + 32'(br_off);
         2'b10: pc_n_d = {ifid_pc_q[31:28], index26_d, 2'b00};
         2'b11: pc_n_d = jr_target_d;
         default: pc_n_d = pc_q + 32'd4;
      endcase
   end

   always_comb begin
      ifid_instr_d = imem_rdata;
      ifid_pc_d    = pc_q;
      if (flush) begin
         ifid_instr_d = 32'd0;
         ifid_pc_d    = 32'd0;
      end
   end

   // Stall dominates flush; a dropped flush is re-issued by the hazard unit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         ifid_instr_q <= 32'd0;
         ifid_pc_q    <= 32'd0;
      end else if (!stall) begin
         pc_q         <= pc_n_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
      end
   end

   assign pc_f    = pc_q;
   assign instr_d = ifid_instr_q;
   assign pc_d    = ifid_pc_q;
   assign pc8_d   = ifid_pc_q + 32'd8;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   localparam logic [31:0] RPC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush;
   logic [1:0]  npc_sel;
   logic [15:0] imm16_d;
   logic [25:0] index26_d;
   logic [31:0] jr_target_d;
   logic [11:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] pc_f, instr_d, pc_d, pc8_d;

   logic [31:0] mem [4096];

   int compared = 0;
   int mismatched = 0;

   // Reference state, straight from the architectural rules.
   logic [31:0] m_pc, m_instr, m_pcd;

   fetch_stage #(.RESET_PC(RPC), .IM_ADDR_W(12)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .npc_sel(npc_sel), .imm16_d(imm16_d), .index26_d(index26_d),
      .jr_target_d(jr_target_d), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d),
      .pc_d(pc_d), .pc8_d(pc8_d)
   );

   always #5 clk = ~clk;

   assign imem_rdata = mem[imem_addr];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      logic [31:0] idx;
      idx = ((a - RPC) / 4) % 4096;
      return mem[idx];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".pc_f"}, pc_f, m_pc);
      chk({tag, ".instr_d"}, instr_d, m_instr);
      chk({tag, ".pc_d"}, pc_d, m_pcd);
      chk({tag, ".pc8_d"}, pc8_d, m_pcd + 32'd8);
      chk({tag, ".imem_addr"}, {20'd0, imem_addr}, ((m_pc - RPC) / 4) % 4096);
   endtask

   task automatic model_reset();
      m_pc = RPC; m_instr = 32'd0; m_pcd = 32'd0;
   endtask

   // Drive one cycle of inputs, let the edge happen, update the model, check.
   task automatic step(input logic st, input logic fl, input logic [1:0] sel,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] jr, input string tag);
      logic [31:0] nxt;
      stall = st; flush = fl; npc_sel = sel;
      imm16_d = imm; index26_d = idx; jr_target_d = jr;
      @(posedge clk);
      if (!st) begin
         case (sel)
            2'b00: nxt = m_pc + 4;
            2'b01: nxt = m_pcd + 4 + 32'($signed(imm) * 4);
            2'b10: nxt = (m_pcd & 32'hF000_0000) | (32'(idx) * 4);
            default: nxt = jr;
         endcase
         if (fl) begin
            m_instr = 32'd0; m_pcd = 32'd0;
         end else begin
            m_instr = word_at(m_pc); m_pcd = m_pc;
         end
         m_pc = nxt;
      end
      #1;
      chk_model(tag);
   endtask

   initial begin
      logic [31:0] held_pc, held_instr, held_pcd;
      for (int i = 0; i < 4096; i++) mem[i] = $urandom;
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;

      reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_sel = 2'b00;
      imm16_d = '0; index26_d = '0; jr_target_d = '0;
      model_reset();
      #3;
      chk("rst.pc_f", pc_f, 32'h3000);
      chk("rst.instr_d", instr_d, 32'd0);
      chk("rst.pc_d", pc_d, 32'd0);
      chk("rst.pc8_d", pc8_d, 32'd8);
      chk("rst.imem_addr", {20'd0, imem_addr}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Sequential fetch
      step(0, 0, 2'b00, 0, 0, 0, "seq0");
      chk("seq0.instr", instr_d, 32'h1111_1111);
      chk("seq0.pc_d", pc_d, 32'h3000);
      step(0, 0, 2'b00, 0, 0, 0, "seq1");
      chk("seq1.instr", instr_d, 32'h2222_2222);
      chk("seq1.pc8", pc8_d, 32'h300C);
      step(0, 0, 2'b00, 0, 0, 0, "seq2");
      chk("seq2.instr", instr_d, 32'h3333_3333);
      chk("seq2.pc_d", pc_d, 32'h3008);
      step(0, 0, 2'b00, 0, 0, 0, "seq3");
      step(0, 0, 2'b00, 0, 0, 0, "seq4");
      chk("seq4.pc_d", pc_d, 32'h3010);

      // Taken branch, negative offset; delay slot at 0x3014 proceeds
      step(0, 0, 2'b01, 16'hFFFC, 0, 0, "br");
      chk("br.pc_f", pc_f, 32'h3004);
      chk("br.delay_slot", instr_d, mem[5]);
      step(0, 0, 2'b00, 0, 0, 0, "br.tgt");
      chk("br.tgt.instr", instr_d, mem[1]);

      // Jump from pc_d = 0x3020, then jr
      step(0, 0, 2'b11, 0, 0, 32'h3020, "jr1");
      step(0, 0, 2'b00, 0, 0, 0, "jr1b");
      chk("j.pc_d", pc_d, 32'h3020);
      step(0, 0, 2'b10, 0, 26'h0000C40, 0, "j");
      chk("j.pc_f", pc_f, 32'h3100);
      step(0, 0, 2'b11, 0, 0, 32'h3200, "jr2");
      chk("jr2.pc_f", pc_f, 32'h3200);

      // Stall 3 cycles with a branch select pending
      held_pc = pc_f; held_instr = instr_d; held_pcd = pc_d;
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 2'b01, 16'h0040, 0, 0, "stall");
         chk("stall.pc_f", pc_f, held_pc);
         chk("stall.instr", instr_d, held_instr);
         chk("stall.pc_d", pc_d, held_pcd);
      end
      step(0, 0, 2'b00, 0, 0, 0, "unstall");
      chk("unstall.pc_f", pc_f, held_pc + 32'd4);
      chk("unstall.pc_d", pc_d, held_pc);

      // Flush alone, then stall+flush
      held_pc = pc_f;
      step(0, 1, 2'b00, 0, 0, 0, "flush");
      chk("flush.instr", instr_d, 32'd0);
      chk("flush.pc_d", pc_d, 32'd0);
      chk("flush.pc_f", pc_f, held_pc + 32'd4);
      step(0, 0, 2'b00, 0, 0, 0, "refill");
      held_pc = pc_f; held_instr = instr_d; held_pcd = pc_d;
      step(1, 1, 2'b00, 0, 0, 0, "stfl");
      chk("stfl.pc_f", pc_f, held_pc);
      chk("stfl.instr", instr_d, held_instr);
      chk("stfl.pc_d", pc_d, held_pcd);

      // Async reset mid-run at pc_f = 0x3040
      step(0, 0, 2'b11, 0, 0, 32'h3040, "pre_arst");
      chk("pre_arst.pc_f", pc_f, 32'h3040);
      #2 reset = 1'b1;
      stall = 1'b1; flush = 1'b1; npc_sel = 2'b11;
      #1;
      chk("arst.pc_f", pc_f, 32'h3000);
      chk("arst.instr", instr_d, 32'd0);
      chk("arst.pc_d", pc_d, 32'd0);
      model_reset();
      #2 reset = 1'b0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(5) == 0), ($urandom_range(7) == 0),
              2'($urandom_range(3)), 16'($urandom), 26'($urandom),
              RPC + 32'($urandom_range(16383)), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
